// File: rtl/gen_bus_mem_responder.sv
// Generic-bus memory responder: a register-array backing store that answers
// single-word reads and byte-enabled writes after LATENCY wait states.
module gen_bus_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hBAD0_BAD0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);
  localparam int unsigned IDX_W = (MEM_WORDS > 32'd1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) << 32'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_ben;
  logic              r_is_wr;
  logic              r_in_range;
  logic [31:0]       r_rdata_hold;
  logic [31:0]       r_mem [MEM_WORDS];

  logic [31:0]       w_offset;
  logic              w_in_range;
  logic              w_req;
  logic              w_capture;
  logic [31:0]       w_rd_word;

  generate
    if (LATENCY > 32'd15) begin : g_latency_check
      $error("gen_bus_mem_responder: LATENCY must be in 0..15");
    end
  endgenerate

  assign w_offset   = addr - BASE_ADDR;
  assign w_in_range = (addr >= BASE_ADDR) && ({1'b0, w_offset} < LIMIT);
  assign w_req      = ren | wen;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    busy      = 1'b1;
    err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          w_next    = (LATENCY == 32'd0) ? RESP : WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        // Initiator withdrawing both strobes abandons the request.
        if (!w_req) begin
          w_next = IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = RESP;
        end else begin
          w_next = WAIT;
        end
      end
      RESP: begin
        busy   = 1'b0;
        err    = ~r_in_range;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Read data: live from the captured index in RESP, held otherwise
  always_comb begin
    w_rd_word = r_in_range ? r_mem[r_idx] : ERR_DATA;
    if ((r_state == RESP) && !r_is_wr) begin
      rdata = w_rd_word;
    end else begin
      rdata = r_rdata_hold;
    end
  end

  // Request capture and wait-state counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_ben      <= 4'd0;
      r_is_wr    <= 1'b0;
      r_in_range <= 1'b0;
    end else if (w_capture) begin
      r_cnt      <= 4'(LATENCY);
      r_idx      <= w_offset[IDX_W+1:2];
      r_wdata    <= wdata;
      r_ben      <= byte_en;
      r_is_wr    <= wen;
      r_in_range <= w_in_range;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Hold the last read word so rdata stays stable between responses
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rdata_hold <= 32'd0;
    end else if ((r_state == RESP) && !r_is_wr) begin
      r_rdata_hold <= w_rd_word;
    end
  end

  // Memory array: cleared on reset, byte lanes committed on leaving RESP
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if ((r_state == RESP) && r_is_wr && r_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (r_ben[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_gen_bus_mem_responder.sv
// Self-checking bench for gen_bus_mem_responder: four instances at LATENCY
// 2, 0, 1 and 15 share stimulus; a scoreboard holds expected read responses.
module tb_gen_bus_mem_responder;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  byte_en = 4'd0;
  logic [31:0] rdata_v [4];
  logic [3:0]  busy_v;
  logic [3:0]  err_v;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] mdl [1024];

  always #5 CLK = ~CLK;

  gen_bus_mem_responder #(.LATENCY(2)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata_v[0]), .busy(busy_v[0]), .err(err_v[0]));
  gen_bus_mem_responder #(.LATENCY(0)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata_v[1]), .busy(busy_v[1]), .err(err_v[1]));
  gen_bus_mem_responder #(.LATENCY(1)) u_lat1 (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata_v[2]), .busy(busy_v[2]), .err(err_v[2]));
  gen_bus_mem_responder #(.LATENCY(15)) u_lat15 (
    .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata_v[3]), .busy(busy_v[3]), .err(err_v[3]));

  // Reference memory for the LATENCY=2 instance (1024 words at base 0).
  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    if (a < 32'h0000_1000) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mdl[a[11:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endfunction

  task automatic apply_reset();
    nRST = 1'b0; ren = 1'b0; wen = 1'b0;
    addr = 32'd0; wdata = 32'd0; byte_en = 4'd0;
    for (int i = 0; i < 1024; i++) mdl[i] = 32'd0;
    sb.delete();
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Drives one request from an IDLE cycle; reports cycles to busy=0 (-1 on
  // timeout), the response, and busy one cycle after the response.
  task automatic run_txn(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int cyc,
                         output logic [31:0] rd, output logic er,
                         output logic busy_after);
    addr = a; wdata = d; byte_en = be; ren = r; wen = w;
    cyc = -1; rd = 32'd0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK); #1;
      if (busy_v[sel] == 1'b0) begin
        cyc = i; rd = rdata_v[sel]; er = err_v[sel];
        break;
      end
    end
    ren = 1'b0; wen = 1'b0;
    @(posedge CLK); #1;
    busy_after = busy_v[sel];
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #3;
    checks++;
    if (busy_v !== 4'hF || err_v !== 4'h0 || rdata_v[0] !== 32'd0 || rdata_v[3] !== 32'd0) begin
      failures++;
      $display("FAIL reset_async: busy=%h err=%h rdata0=%h required busy=f err=0 rdata=0",
               busy_v, err_v, rdata_v[0]);
    end
    apply_reset();
    checks++;
    if (busy_v !== 4'hF || err_v !== 4'h0 || rdata_v[1] !== 32'd0 || rdata_v[2] !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle: busy=%h err=%h required busy=f err=0", busy_v, err_v);
    end
  endtask

  task automatic test_first_read();
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    sb.push_back(exp_t'{rdata: 32'h0000_0000, err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL first_read_latency: got %0d required 3", cyc); end
    checks++;
    if (one !== 1'b1) begin failures++; $display("FAIL first_read_pulse: busy after %b required 1", one); end
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++;
      $display("FAIL first_read_data: got %h/%b required %h/%b", rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_write_read();
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    run_txn(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, cyc, rd, er, one);
    model_write(32'h40, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (cyc !== 3 || er !== 1'b0) begin
      failures++; $display("FAIL write_full: cycles=%0d err=%b required 3/0", cyc, er);
    end
    sb.push_back(exp_t'{rdata: 32'hDEAD_BEEF, err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (cyc !== 3 || rd !== e.rdata || er !== e.err) begin
      failures++;
      $display("FAIL readback_full: cycles=%0d data=%h required 3/%h", cyc, rd, e.rdata);
    end
  endtask

  task automatic test_partial();
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    run_txn(0, 1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, cyc, rd, er, one);
    model_write(32'h40, 32'h1122_3344, 4'b0101);
    sb.push_back(exp_t'{rdata: 32'hDE22_BE44, err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h43, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++; $display("FAIL partial_write: got %h required %h", rd, e.rdata);
    end
  endtask

  task automatic test_mem_scan(input string tag);
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    for (int i = 0; i < 1024; i++) begin
      sb.push_back(exp_t'{rdata: mdl[i], err: 1'b0});
      run_txn(0, 1'b1, 1'b0, 32'(i) << 2, 32'd0, 4'h0, cyc, rd, er, one);
      e = sb.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err || cyc !== 3) begin
        failures++;
        $display("FAIL scan_%s word %0d: got %h/%b cyc=%0d required %h/%b cyc=3",
                 tag, i, rd, er, cyc, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_out_of_range();
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    sb.push_back(exp_t'{rdata: 32'hBAD0_BAD0, err: 1'b1});
    run_txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err || cyc !== 3) begin
      failures++; $display("FAIL oor_read: got %h/%b required %h/%b", rd, er, e.rdata, e.err);
    end
    sb.push_back(exp_t'{rdata: 32'h0000_0000, err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++; $display("FAIL last_word_read: got %h/%b required %h/%b", rd, er, e.rdata, e.err);
    end
    run_txn(0, 1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, cyc, rd, er, one);
    checks++;
    if (er !== 1'b1 || cyc !== 3) begin
      failures++; $display("FAIL oor_write_err: err=%b cyc=%0d required 1/3", er, cyc);
    end
    test_mem_scan("oor");
  endtask

  task automatic test_abort();
    int cyc; logic [31:0] rd; logic er, one; exp_t e; logic saw_done;
    addr = 32'h20; wdata = 32'h0000_0077; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK); #1;
    wen = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy_v[0] == 1'b0) saw_done = 1'b1;
      @(posedge CLK); #1;
    end
    checks++;
    if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_busy: busy went 0, required stay 1"); end
    sb.push_back(exp_t'{rdata: mdl[8], err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || cyc !== 3) begin
      failures++; $display("FAIL abort_no_write: got %h cyc=%0d required %h cyc=3", rd, cyc, e.rdata);
    end
  endtask

  task automatic test_simultaneous();
    int cyc; logic [31:0] rd; logic er, one; exp_t e;
    run_txn(0, 1'b1, 1'b1, 32'h80, 32'h0000_0005, 4'hF, cyc, rd, er, one);
    model_write(32'h80, 32'h0000_0005, 4'hF);
    sb.push_back(exp_t'{rdata: 32'h0000_0005, err: 1'b0});
    run_txn(0, 1'b1, 1'b0, 32'h80, 32'd0, 4'h0, cyc, rd, er, one);
    e = sb.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin
      failures++; $display("FAIL ren_wen_write: got %h required %h", rd, e.rdata);
    end
  endtask

  task automatic test_burst(input int sel, input int lat);
    logic [31:0] a, rd; int n, last, cyc; logic er, one; exp_t e;
    apply_reset();
    for (int op = 0; op < 2; op++) begin
      n = 0; last = 0; a = 32'h100;
      if (op == 1) begin
        for (int k = 0; k < 4; k++) sb.push_back(exp_t'{rdata: {16'hA500, 8'(lat), 8'(k)}, err: 1'b0});
      end
      addr = a; wdata = {16'hA500, 8'(lat), 8'd0}; byte_en = 4'hF;
      wen = (op == 0); ren = (op == 1);
      for (int c = 1; c <= 400 && n < 4; c++) begin
        @(posedge CLK); #1;
        if (busy_v[sel] == 1'b0) begin
          if (n > 0) begin
            checks++;
            if (c - last !== lat + 2) begin
              failures++; $display("FAIL burst_spacing lat=%0d op=%0d: got %0d required %0d", lat, op, c - last, lat + 2);
            end
          end
          if (op == 1) begin
            e = sb.pop_front();
            checks++;
            if (rdata_v[sel] !== e.rdata || err_v[sel] !== e.err) begin
              failures++; $display("FAIL burst_data lat=%0d word %0d: got %h required %h", lat, n, rdata_v[sel], e.rdata);
            end
          end
          last = c; n++; a = a + 32'd4; addr = a;
          wdata = {16'hA500, 8'(lat), 8'(n)};
          if (n == 4) begin ren = 1'b0; wen = 1'b0; end
        end
      end
      ren = 1'b0; wen = 1'b0;
      checks++;
      if (n !== 4) begin failures++; $display("FAIL burst_timeout lat=%0d op=%0d: got %0d words required 4", lat, op, n); end
      sb.delete();
      @(posedge CLK); #1;
    end
    run_txn(sel, 1'b1, 1'b0, 32'h0FC, 32'd0, 4'h0, cyc, rd, er, one);
    checks++;
    if (rd !== 32'd0 || cyc !== lat + 1) begin
      failures++; $display("FAIL burst_below lat=%0d: got %h cyc=%0d required 0 cyc=%0d", lat, rd, cyc, lat + 1);
    end
    run_txn(sel, 1'b1, 1'b0, 32'h110, 32'd0, 4'h0, cyc, rd, er, one);
    checks++;
    if (rd !== 32'd0) begin failures++; $display("FAIL burst_above lat=%0d: got %h required 0", lat, rd); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] rd; logic er, one;
    run_txn(0, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, cyc, rd, er, one);
    run_txn(0, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, cyc, rd, er, one);
    checks++;
    if (rd !== 32'h1234_5678) begin failures++; $display("FAIL pre_reset_write: got %h required 12345678", rd); end
    addr = 32'h44; wdata = 32'hCAFE_F00D; byte_en = 4'hF; wen = 1'b1;
    @(posedge CLK); #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (busy_v[0] !== 1'b1 || rdata_v[0] !== 32'd0 || err_v[0] !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs: busy=%b rdata=%h err=%b required 1/0/0", busy_v[0], rdata_v[0], err_v[0]);
    end
    wen = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 0; i < 1024; i++) mdl[i] = 32'd0;
    @(posedge CLK); #1;
    test_mem_scan("after_reset");
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_partial();
    test_out_of_range();
    test_abort();
    test_simultaneous();
    test_burst(1, 0);
    test_burst(2, 1);
    test_burst(3, 15);
    test_burst(0, 2);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
